// File: rtl/perf_counter_ctrl_if.sv
// MMIO bus between the CPU data path and the performance-counter block.
// The CPU side drives strobes, address and write data; the block returns
// registered read data.
interface perf_counter_ctrl_if;
  logic        mmio_we;
  logic        mmio_re;
  logic [2:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;

  modport master (
    output mmio_we,
    output mmio_re,
    output mmio_addr,
    output mmio_wdata,
    input  mmio_rdata
  );

  modport slave (
    input  mmio_we,
    input  mmio_re,
    input  mmio_addr,
    input  mmio_wdata,
    output mmio_rdata
  );
endinterface

// File: rtl/perf_counter_ctrl.sv
// Cycle / retired-instruction performance counters with MMIO control:
// start, stop, clear, atomic snapshot and an optional instruction-count
// limit that parks the block in DONE and emits a one-cycle done pulse.
module perf_counter_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_retire,
  perf_counter_ctrl_if.slave   mmio,
  output logic [CNT_WIDTH-1:0] cycle_counter,
  output logic [CNT_WIDTH-1:0] instruction_counter,
  output logic                 running,
  output logic                 done_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_CYC    = 3'd2;
  localparam logic [2:0] A_INS    = 3'd3;
  localparam logic [2:0] A_CSNAP  = 3'd4;
  localparam logic [2:0] A_ISNAP  = 3'd5;
  localparam logic [2:0] A_LIMIT  = 3'd6;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q;
  logic                 running_q;
  logic                 done_q;
  logic                 hit_q;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] ins_q, ins_d;
  logic [CNT_WIDTH-1:0] cyc_snap_q;
  logic [CNT_WIDTH-1:0] ins_snap_q;
  logic                 cyc_ovf_q, cyc_ovf_d;
  logic                 ins_ovf_q, ins_ovf_d;
  logic [31:0]          limit_q;
  logic [31:0]          rdata_q, rdata_d;

  logic                 ctrl_wr;
  logic                 start_c, stop_c, clear_c, snap_c;
  logic                 limit_wr;
  logic                 limit_fire;
  logic [CNT_WIDTH-1:0] ins_inc;

  assign ctrl_wr  = mmio.mmio_we && (mmio.mmio_addr == A_CTRL);
  assign start_c  = ctrl_wr && mmio.mmio_wdata[0];
  assign stop_c   = ctrl_wr && mmio.mmio_wdata[1];
  assign clear_c  = ctrl_wr && mmio.mmio_wdata[2];
  assign snap_c   = ctrl_wr && mmio.mmio_wdata[3];
  assign limit_wr = mmio.mmio_we && (mmio.mmio_addr == A_LIMIT);

  assign ins_inc  = ins_q + CNT_ONE;

  // The limit only fires on a counted retire that lands exactly on LIMIT;
  // a same-cycle STOP or CLEAR takes precedence over the automatic stop.
  assign limit_fire = (state_q == ST_RUN) && inst_retire && !stop_c && !clear_c &&
                      (limit_q != 32'd0) && (32'(ins_inc) == limit_q);

  // Next counter values: CLEAR beats counting, counting only while in RUN.
  always_comb begin
    cyc_d     = cyc_q;
    ins_d     = ins_q;
    cyc_ovf_d = cyc_ovf_q;
    ins_ovf_d = ins_ovf_q;
    if (clear_c) begin
      cyc_d     = '0;
      ins_d     = '0;
      cyc_ovf_d = 1'b0;
      ins_ovf_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      cyc_d = cyc_q + CNT_ONE;
      if (cyc_q == '1) cyc_ovf_d = 1'b1;
      if (inst_retire) begin
        ins_d = ins_inc;
        if (ins_q == '1) ins_ovf_d = 1'b1;
      end
    end
  end

  // Register file: counters, sticky flags, snapshots and LIMIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q      <= '0;
      ins_q      <= '0;
      cyc_ovf_q  <= 1'b0;
      ins_ovf_q  <= 1'b0;
      cyc_snap_q <= '0;
      ins_snap_q <= '0;
      limit_q    <= 32'd0;
    end else begin
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
      cyc_ovf_q <= cyc_ovf_d;
      ins_ovf_q <= ins_ovf_d;
      if (snap_c) begin
        cyc_snap_q <= cyc_q;
        ins_snap_q <= ins_q;
      end
      if (limit_wr) limit_q <= mmio.mmio_wdata;
    end
  end

  // Control FSM with registered running / done_pulse / limit-hit; STOP wins over START.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_c && !stop_c) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop_c) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end else if (limit_fire) begin
            state_q   <= ST_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (stop_c) begin
            state_q <= ST_IDLE;
          end else if (start_c) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
      if (limit_fire) begin
        hit_q <= 1'b1;
      end else if (clear_c) begin
        hit_q <= 1'b0;
      end
    end
  end

  // Read mux over pre-update register values, so a same-cycle write is not visible.
  always_comb begin
    rdata_d = 32'd0;
    case (mmio.mmio_addr)
      A_STATUS: rdata_d = {27'd0, hit_q, ins_ovf_q, cyc_ovf_q, state_q};
      A_CYC:    rdata_d = 32'(cyc_q);
      A_INS:    rdata_d = 32'(ins_q);
      A_CSNAP:  rdata_d = 32'(cyc_snap_q);
      A_ISNAP:  rdata_d = 32'(ins_snap_q);
      A_LIMIT:  rdata_d = limit_q;
      default:  rdata_d = 32'd0;
    endcase
  end

  // Read data register: loads on a read strobe and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= 32'd0;
    end else if (mmio.mmio_re) begin
      rdata_q <= rdata_d;
    end
  end

  assign mmio.mmio_rdata     = rdata_q;
  assign cycle_counter       = cyc_q;
  assign instruction_counter = ins_q;
  assign running             = running_q;
  assign done_pulse          = done_q;

endmodule

// File: doc/perf_counter_ctrl.md
# perf_counter_ctrl

Memory-mapped controller for the CPU's cycle and retired-instruction performance counters. Software running from BIOS memory (e.g. the mmult benchmark) uses it to start, stop, clear and snapshot the counters. It can also arm an instruction-count limit that stops counting automatically and raises a done pulse. It sits on the CPU's MMIO data path next to the UART and drives the counter values that benches read out to compute CPI.

## Interface
Parameters:
- CNT_WIDTH, 32, width of both counters (≤ 32; MMIO reads zero-extend)

Ports:
- clk  in  1  CPU clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clk)
- inst_retire  in  1  one-cycle pulse per retired instruction from the CPU writeback stage
- mmio_we  in  1  write strobe, single cycle
- mmio_re  in  1  read strobe, single cycle
- mmio_addr  in  3  word index (byte offset [4:2]) within the block
- mmio_wdata  in  32  write data
- mmio_rdata  out  32  registered read data
- cycle_counter  out  CNT_WIDTH  live cycle count
- instruction_counter  out  CNT_WIDTH  live retired-instruction count
- running  out  1  high while in RUN
- done_pulse  out  1  one-cycle pulse when the limit stop fires

## Operation
Register map (word index):
- 0 CTRL, write-only. Bit0 START, bit1 STOP, bit2 CLEAR, bit3 SNAP. Reads return 0.
- 1 STATUS, read-only. [1:0] state (0 IDLE, 1 RUN, 2 DONE), bit2 cycle overflow, bit3 instr overflow, bit4 limit-hit.
- 2 CYCLE live, 3 INSTR live. Read-only.
- 4 CYCLE_SNAP, 5 INSTR_SNAP. Read-only.
- 6 LIMIT, read/write. 0 = disabled.
- 7 reserved. Reads 0, writes ignored.

States:
- IDLE → RUN on START.
- RUN → IDLE on STOP.
- RUN → DONE when LIMIT ≠ 0 and the instruction counter's next value equals LIMIT. done_pulse fires that cycle and limit-hit is set.
- DONE → RUN on START. Counters continue from their held values; limit-hit stays set.
- DONE → IDLE on STOP.
- CLEAR in any state zeroes both counters, both overflow flags and limit-hit. CLEAR does not change the state or the snapshots.

Counting and overflow:
- In RUN, the cycle counter adds 1 every cycle.
- In RUN, the instruction counter adds 1 per inst_retire.
- Both counters wrap modulo 2^CNT_WIDTH. A wrap from all-ones to 0 sets the sticky overflow bit; only CLEAR or reset clears it.
- Outside RUN, both counters hold.

Snapshots:
- SNAP copies the live values into CYCLE_SNAP and INSTR_SNAP in the same cycle. The copy is atomic: both counters are captured from the same cycle's pre-update values.

Simultaneous CTRL bits (in one write):
- CLEAR with START: counters read 0 on the next cycle, and counting begins the cycle after that.
- STOP wins over START.
- SNAP with CLEAR: the snapshot captures the pre-clear values.

Other boundary cases:
- Writes to read-only words are ignored.
- Writing LIMIT in RUN takes effect from the next cycle.
- Setting LIMIT to a value ≤ the current count does not stop counting until the counter wraps back to that value.

## Timing
- Reset values: state IDLE, both counters 0, both snapshots 0, LIMIT 0, all flags 0, mmio_rdata 0, running 0, done_pulse 0.
- Reset mid-run overrides everything, including a same-cycle MMIO write.
- The state is sampled at the start of the cycle:
  - The cycle in which STOP is written still counts (cycle and any retire).
  - The cycle in which START is written does not count.
- running updates one cycle after the write edge, together with the state register.
- Read latency is 1. mmio_rdata is valid on the cycle after mmio_re and holds until the next read.
- A live-counter read returns the value registered at the mmio_re edge.
- A read and a write in the same cycle are legal. The read returns the pre-write value.
- done_pulse is asserted for exactly one cycle, the cycle after the limit-reaching retire. No new retires are counted after that.

## Test plan
- Reset, then write START. Run 100 cycles with inst_retire high every other cycle, then write STOP → CYCLE = 101, INSTR = 50 (±1 per the pattern phase, which the bench computes exactly), running = 0.
- Set LIMIT = 10, write START, hold inst_retire = 1 → done_pulse exactly once, on the cycle after the 10th retire. STATUS = 0x12, INSTR = 10 and holds.
- Preload the counters near wrap by running with CNT_WIDTH = 8 for 260 cycles → CYCLE wraps to a small value, STATUS bit2 = 1. Write CLEAR → bit2 = 0, CYCLE = 0.
- Write START|CLEAR|SNAP while counters are nonzero → snapshots hold the old values, live counters are 0 next cycle, then increment.
- While in RUN, assert rst = 0 for one cycle coincident with a CTRL write → all outputs return to reset values and the write is dropped.
- Read each word with back-to-back mmio_re → correct data one cycle after each strobe. Word 0 and word 7 read 0, and writes to word 2 leave CYCLE unchanged.
